// File: rtl/wb_initiator.sv
// ---------------------------------------------------------------------------
// wb_initiator
//
// Turns a single valid/ready command into one Wishbone classic bus cycle and
// returns the outcome as a valid/ready response.  Exactly one transfer can be
// outstanding: a new command is only taken once the previous response has
// been consumed.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i
//                         command: direction, address, write data, byte selects
//   rsp_valid_o/ready_i   response handshake
//   rsp_dat_o             read data (0 for writes and errored transfers)
//   rsp_err_o             ended by err_i or by timeout
//   rsp_timeout_o         ended by timeout
//   cyc_o, stb_o, we_o, adr_o, dat_o, sel_o
//                         Wishbone initiator outputs
//   dat_i, ack_i, err_i   Wishbone responder data and terminations
// ---------------------------------------------------------------------------
module wb_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_dat_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_dat_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic                    we_o,
    output logic [ADDR_WIDTH-1:0]   adr_o,
    output logic [DATA_WIDTH-1:0]   dat_o,
    output logic [DATA_WIDTH/8-1:0] sel_o,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic                    ack_i,
    input  logic                    err_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The counter holds the number of BUS cycles already completed, so the
    // timeout fires on the edge that closes cycle number TIMEOUT.
    localparam int TMO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic                    cmd_we;
    logic [ADDR_WIDTH-1:0]   cmd_adr;
    logic [DATA_WIDTH-1:0]   cmd_dat;
    logic [SEL_WIDTH-1:0]    cmd_sel;

    logic [DATA_WIDTH-1:0]   rsp_dat;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic [CNT_WIDTH-1:0]    tmo_cnt;

    logic                    accept;
    logic                    timeout_fire;
    logic                    bus_done;

    assign accept       = (state == ST_IDLE) && cmd_valid_i;
    assign timeout_fire = (TIMEOUT != 0) && (tmo_cnt == CNT_WIDTH'(TMO_LAST));
    assign bus_done     = ack_i || err_i || timeout_fire;

    // State register.  Reset is asynchronous so a transfer in flight is
    // abandoned, and the bus released, the moment rst_i rises.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (cmd_valid_i) next_state = ST_BUS;
            ST_BUS:  if (bus_done)    next_state = ST_RESP;
            ST_RESP: if (rsp_ready_i) next_state = ST_IDLE;
            default:                  next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the state alone, so the asynchronous reset
    // drops cyc_o/stb_o without waiting for a clock edge.
    always_comb begin
        cmd_ready_o   = 1'b0;
        cyc_o         = 1'b0;
        stb_o         = 1'b0;
        we_o          = 1'b0;
        adr_o         = '0;
        dat_o         = '0;
        sel_o         = '0;
        rsp_valid_o   = 1'b0;
        rsp_dat_o     = '0;
        rsp_err_o     = 1'b0;
        rsp_timeout_o = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
            end
            ST_BUS: begin
                cyc_o = 1'b1;
                stb_o = 1'b1;
                we_o  = cmd_we;
                adr_o = cmd_adr;
                dat_o = cmd_dat;
                sel_o = cmd_sel;
            end
            ST_RESP: begin
                rsp_valid_o   = 1'b1;
                rsp_dat_o     = rsp_dat;
                rsp_err_o     = rsp_err;
                rsp_timeout_o = rsp_timeout;
            end
            default: begin
                cmd_ready_o = 1'b0;
            end
        endcase
    end

    // Command capture, timeout counting and response capture.  Termination
    // priority is err_i, then ack_i, then timeout, so a responder that
    // answers on the same edge the timeout expires is still honoured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_we      <= 1'b0;
            cmd_adr     <= '0;
            cmd_dat     <= '0;
            cmd_sel     <= '0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            if (accept) begin
                cmd_we  <= cmd_we_i;
                cmd_adr <= cmd_adr_i;
                cmd_dat <= cmd_dat_i;
                cmd_sel <= cmd_sel_i;
                tmo_cnt <= '0;
            end else if (state == ST_BUS) begin
                if (err_i) begin
                    rsp_dat     <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b0;
                end else if (ack_i) begin
                    rsp_dat     <= cmd_we ? '0 : dat_i;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                end else if (timeout_fire) begin
                    rsp_dat     <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_wb_initiator
//
// Directed bench for wb_initiator (TIMEOUT = 8).  Each scenario describes a
// transfer abstractly (command, responder wait states and termination,
// response hold-off); the expected outputs for every cycle are derived from
// that description, and a per-scenario set of hand-computed literals pins
// the stb_o length and the delivered response.
// ---------------------------------------------------------------------------
module tb_wb_initiator;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic        err_i;

    wb_initiator #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_we_i      (cmd_we_i),
        .cmd_adr_i     (cmd_adr_i),
        .cmd_dat_i     (cmd_dat_i),
        .cmd_sel_i     (cmd_sel_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_dat_o     (rsp_dat_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .cyc_o         (cyc_o),
        .stb_o         (stb_o),
        .we_o          (we_o),
        .adr_o         (adr_o),
        .dat_o         (dat_o),
        .sel_o         (sel_o),
        .dat_i         (dat_i),
        .ack_i         (ack_i),
        .err_i         (err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        cmd_ready;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        rsp_valid;
        logic [31:0] rsp_dat;
        logic        rsp_err;
        logic        rsp_to;
    } out_t;

    // term: bit0 = responder acks, bit1 = responder errs, 0 = silent.
    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          wait_n;
        logic [1:0]  term;
        logic [31:0] rdata;
        int          hold;
        int          lit_stb;
        logic [31:0] lit_dat;
        logic        lit_err;
        logic        lit_to;
    } scen_t;

    // Shared between driver (writer) and compare process (reader).
    out_t        exp_out;
    logic        exp_on  = 1'b0;
    logic        lit_now = 1'b0;
    logic        lit_rsp = 1'b0;
    int          lit_stb = 0;
    logic [31:0] lit_dat = '0;
    logic        lit_err = 1'b0;
    logic        lit_to  = 1'b0;

    // Owned by the compare process.
    int          errors   = 0;
    int          checks   = 0;
    int          stb_cnt  = 0;
    logic        rsp_seen = 1'b0;
    logic [31:0] cap_dat  = '0;
    logic        cap_err  = 1'b0;
    logic        cap_to   = 1'b0;
    int          rst_seen = 0;

    // Owned by the reset monitor.
    logic [2:0]  rst_snap     = '0;
    int          rst_snap_cnt = 0;

    function automatic scen_t mk(logic we, logic [31:0] adr, logic [31:0] dat,
                                 logic [3:0] sel, int wait_n, logic [1:0] term,
                                 logic [31:0] rdata, int hold, int l_stb,
                                 logic [31:0] l_dat, logic l_err, logic l_to);
        scen_t s;
        s.we = we;  s.adr = adr;  s.dat = dat;  s.sel = sel;
        s.wait_n = wait_n;  s.term = term;  s.rdata = rdata;  s.hold = hold;
        s.lit_stb = l_stb;  s.lit_dat = l_dat;  s.lit_err = l_err;  s.lit_to = l_to;
        return s;
    endfunction

    // The responder answers in cycle wait_n+1 of the bus phase; if that is
    // later than the timeout, or it never answers, the timeout ends it.
    function automatic logic answered(scen_t s);
        return (s.term != 2'b00) && (s.wait_n + 1 <= TMO);
    endfunction

    function automatic int bus_cycles(scen_t s);
        return answered(s) ? s.wait_n + 1 : TMO;
    endfunction

    function automatic out_t idle_out();
        out_t o;
        o = '0;
        o.cmd_ready = 1'b1;
        return o;
    endfunction

    // Cycle 0 is the accept cycle; cycles 1..n carry the strobe; the response
    // is offered for hold+1 cycles; everything else is idle.
    function automatic out_t expect_cycle(scen_t s, int c);
        out_t o;
        int   n;
        n = bus_cycles(s);
        o = idle_out();
        if (c >= 1 && c <= n) begin
            o.cmd_ready = 1'b0;
            o.cyc = 1'b1;
            o.stb = 1'b1;
            o.we  = s.we;
            o.adr = s.adr;
            o.dat = s.dat;
            o.sel = s.sel;
        end else if (c > n && c <= n + 1 + s.hold) begin
            o.cmd_ready = 1'b0;
            o.rsp_valid = 1'b1;
            o.rsp_err   = answered(s) ? s.term[1] : 1'b1;
            o.rsp_to    = !answered(s);
            o.rsp_dat   = (answered(s) && s.term == 2'b01 && !s.we) ? s.rdata : 32'h0;
        end
        return o;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of a scenario and publish what the outputs must be.
    // A stray command is held on cmd_valid_i through the bus and response
    // phases; it must never be taken.
    task automatic drive_cycle(input scen_t s, input int c, input logic last);
        int n;
        n = bus_cycles(s);
        cmd_valid_i = (c <= n + s.hold);
        if (c == 0) begin
            cmd_we_i  = s.we;
            cmd_adr_i = s.adr;
            cmd_dat_i = s.dat;
            cmd_sel_i = s.sel;
        end else begin
            cmd_we_i  = ~s.we;
            cmd_adr_i = s.adr ^ 32'hFFFF_0000;
            cmd_dat_i = ~s.dat;
            cmd_sel_i = ~s.sel;
        end
        ack_i       = s.term[0] && (c == s.wait_n + 1) && (c <= n);
        err_i       = s.term[1] && (c == s.wait_n + 1) && (c <= n);
        dat_i       = (c == s.wait_n + 1) ? s.rdata : (32'h5A5A_0000 | 32'(c));
        rsp_ready_i = (c >= n + 1 + s.hold);
        exp_out     = expect_cycle(s, c);
        exp_on      = 1'b1;
        lit_rsp     = 1'b1;
        lit_stb     = s.lit_stb;
        lit_dat     = s.lit_dat;
        lit_err     = s.lit_err;
        lit_to      = s.lit_to;
        lit_now     = last;
    endtask

    task automatic apply_stimulus(input scen_t s);
        int last;
        last = bus_cycles(s) + s.hold + 2;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk_i);
            #1;
            drive_cycle(s, c, c == last);
        end
    endtask

    // Start a read to a silent responder, then pulse reset between edges in
    // the fourth bus cycle.  The transfer must vanish without a response.
    task automatic reset_midbus();
        scen_t s;
        s = mk(1'b0, 32'h0000_0060, 32'h0, 4'hF, 0, 2'b00, 32'h0, 0,
               0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c <= 3; c++) begin
            @(posedge clk_i);
            #1;
            drive_cycle(s, c, 1'b0);
        end
        @(posedge clk_i);
        #1;
        exp_on      = 1'b0;
        cmd_valid_i = 1'b0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
        #1;
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            exp_out = idle_out();
            exp_on  = 1'b1;
            lit_rsp = 1'b0;
            lit_stb = 3;
            lit_now = (k == 2);
        end
    endtask

    // Snapshot the bus 1 ns after every rising reset, well before any edge.
    always @(posedge rst_i) begin
        #1;
        rst_snap = {cyc_o, stb_o, rsp_valid_o};
        rst_snap_cnt++;
    end

    // Single compare process: per-cycle model comparison, reset snapshot
    // check, and end-of-scenario literal checks.
    always @(negedge clk_i) begin
        out_t act;
        act.cmd_ready = cmd_ready_o;
        act.cyc       = cyc_o;
        act.stb       = stb_o;
        act.we        = we_o;
        act.adr       = adr_o;
        act.dat       = dat_o;
        act.sel       = sel_o;
        act.rsp_valid = rsp_valid_o;
        act.rsp_dat   = rsp_dat_o;
        act.rsp_err   = rsp_err_o;
        act.rsp_to    = rsp_timeout_o;

        if (rst_snap_cnt != rst_seen) begin
            rst_seen = rst_snap_cnt;
            check_output("async_reset_drop", 128'(rst_snap), 128'(3'b000));
        end

        if (exp_on) begin
            check_output("outputs", 128'(act), 128'(exp_out));
        end

        if (stb_o) stb_cnt++;
        if (rsp_valid_o) begin
            rsp_seen = 1'b1;
            cap_dat  = rsp_dat_o;
            cap_err  = rsp_err_o;
            cap_to   = rsp_timeout_o;
        end

        if (exp_on && lit_now) begin
            check_output("stb_cycles", 128'(stb_cnt), 128'(lit_stb));
            check_output("rsp_seen", 128'(rsp_seen), 128'(lit_rsp));
            if (lit_rsp) begin
                check_output("rsp_dat", 128'(cap_dat), 128'(lit_dat));
                check_output("rsp_err", 128'(cap_err), 128'(lit_err));
                check_output("rsp_timeout", 128'(cap_to), 128'(lit_to));
            end
            stb_cnt  = 0;
            rsp_seen = 1'b0;
        end
    end

    scen_t scen[7];

    initial begin
        //            we    adr           dat           sel   W  term   rdata         hold stb lit_dat       err   to
        scen[0] = mk(1'b0, 32'h0000_0010, 32'h0,        4'hF, 2, 2'b01, 32'hDEAD_BEEF, 0,  3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        scen[1] = mk(1'b1, 32'h0000_0004, 32'h0000_000F, 4'hF, 0, 2'b01, 32'hCAFE_0001, 0,  1, 32'h0,         1'b0, 1'b0);
        scen[2] = mk(1'b0, 32'h0000_0020, 32'h0,        4'hF, 0, 2'b00, 32'h1111_1111, 0,  8, 32'h0,         1'b1, 1'b1);
        scen[3] = mk(1'b0, 32'h0000_0030, 32'h0,        4'hF, 1, 2'b11, 32'hA5A5_A5A5, 0,  2, 32'h0,         1'b1, 1'b0);
        scen[4] = mk(1'b0, 32'h0000_0040, 32'h0,        4'hF, 0, 2'b01, 32'h0BAD_F00D, 5,  1, 32'h0BAD_F00D, 1'b0, 1'b0);
        scen[5] = mk(1'b0, 32'h0000_0050, 32'h0,        4'hF, 7, 2'b01, 32'h1357_2468, 0,  8, 32'h1357_2468, 1'b0, 1'b0);
        scen[6] = mk(1'b1, 32'h0000_0080, 32'h1122_3344, 4'h3, 3, 2'b10, 32'hFFFF_FFFF, 0,  4, 32'h0,         1'b1, 1'b0);

        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        dat_i       = '0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
        exp_out     = idle_out();
        exp_on      = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        foreach (scen[i]) apply_stimulus(scen[i]);
        reset_midbus();

        @(posedge clk_i);
        #1;
        exp_on  = 1'b0;
        lit_now = 1'b0;
        @(negedge clk_i);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
